// File: rtl/onewire_slave.sv
// onewire_slave: 1-Wire responder with reset/presence handling and byte rx/tx.
// Ports: clk/rst (sync, active-high); onewire_i pad level, onewire_e pull-low
// enable; rst_det reset-pulse strobe; rx_data/rx_valid received byte;
// tx_data/tx_valid/tx_ready byte to send; crc running CRC8.
// Optional: define ONEWIRE_SLAVE_CRC_EN to enable the Dallas/Maxim CRC8.
module onewire_slave #(
  parameter int CW     = 16,
  parameter int T_RST  = 8640,
  parameter int T_SMP  = 720,
  parameter int T_TXH  = 1080,
  parameter int T_PDLY = 720,
  parameter int T_PRS  = 2880
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       onewire_i,
  output logic       onewire_e,
  output logic       rst_det,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] crc
);

  localparam logic [CW-1:0] RST_M1   = CW'(T_RST - 1);
  localparam logic [CW-1:0] SMP      = CW'(T_SMP);
  localparam logic [CW-1:0] TXH_END  = CW'(T_TXH - 1);
  localparam logic [CW-1:0] PDLY_END = CW'(T_PDLY - 1);
  localparam logic [CW-1:0] PRS_END  = CW'(T_PRS - 1);

  typedef enum logic [2:0] {
    IDLE, SLOT, RSTW, PDLY, PRES
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    txbuf_q, txbuf_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          txfull_q, txfull_d;
  logic          oe_q, oe_d;
  logic          rdet_q, rdet_d;
  logic          rxv_q, rxv_d;
  logic          rdy_q, rdy_d;
  logic          line, fe, re, load, rst_hit;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  assign line    = sync_q[1];
  assign fe      = sync_q[2] & ~sync_q[1];
  assign re      = ~sync_q[2] & sync_q[1];
  assign load    = tx_valid & rdy_q;
  // fires once, on the cycle the low counter steps onto T_RST
  assign rst_hit = ~fe & ~line & (lcnt_q == RST_M1);

`ifdef ONEWIRE_SLAVE_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_bit(
    input logic [7:0] c,
    input logic       b
  );
    logic [7:0] s;
    s = {1'b0, c[7:1]};
    if (c[0] ^ b) s = s ^ 8'h8C;
    return s;
  endfunction

  assign crc = crc_q;
`else
  assign crc = 8'h00;
`endif

  always_comb begin
    sync_d   = {sync_q[1:0], onewire_i};
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    txbuf_d  = txbuf_q;
    txfull_d = txfull_q;
    rxd_d    = rxd_q;
    oe_d     = oe_q;
    rdet_d   = 1'b0;
    rxv_d    = 1'b0;
`ifdef ONEWIRE_SLAVE_CRC_EN
    crc_d    = crc_q;
`endif
    if (fe)
      lcnt_d = '0;
    else if (!line && !(&lcnt_q))
      lcnt_d = lcnt_q + 1'b1;
    if (load) begin
      txbuf_d  = tx_data;
      txfull_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        // a 0-bit drive can outlast the slot's sample point
        if (oe_q && cnt_q == TXH_END) oe_d = 1'b0;
        if (fe) begin
          state_d = SLOT;
          cnt_d   = '0;
          oe_d    = txfull_d & ~txbuf_d[bcnt_q];
        end
      end
      SLOT: begin
        if (oe_q && cnt_q == TXH_END) oe_d = 1'b0;
        if (cnt_q == SMP) begin
          shift_d = {line, shift_q[7:1]};
`ifdef ONEWIRE_SLAVE_CRC_EN
          crc_d   = crc8_bit(crc_q, line);
`endif
          bcnt_d  = bcnt_q + 3'd1;
          state_d = IDLE;
          if (bcnt_q == 3'd7) begin
            rxd_d    = shift_d;
            rxv_d    = 1'b1;
            txfull_d = 1'b0;
          end
        end
      end
      RSTW: begin
        if (re) begin
          state_d = PDLY;
          cnt_d   = '0;
        end
      end
      PDLY: begin
        if (cnt_q == PDLY_END) begin
          state_d = PRES;
          cnt_d   = '0;
          oe_d    = 1'b1;
        end
      end
      PRES: begin
        // own falling edge is ignored here
        if (cnt_q == PRS_END) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_hit) begin
      state_d  = RSTW;
      oe_d     = 1'b0;
      bcnt_d   = '0;
      txfull_d = 1'b0;
      shift_d  = '0;
      rxd_d    = rxd_q;
      rxv_d    = 1'b0;
      rdet_d   = 1'b1;
`ifdef ONEWIRE_SLAVE_CRC_EN
      crc_d    = '0;
`endif
    end
    // ready only after a full cycle in IDLE at a byte boundary
    rdy_d = (state_d == IDLE) && (state_q == IDLE) &&
            !txfull_d && (bcnt_d == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '1;
      lcnt_q   <= '0;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      txbuf_q  <= '0;
      txfull_q <= 1'b0;
      rxd_q    <= '0;
      oe_q     <= 1'b0;
      rdet_q   <= 1'b0;
      rxv_q    <= 1'b0;
      rdy_q    <= 1'b1;
`ifdef ONEWIRE_SLAVE_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      lcnt_q   <= lcnt_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      txbuf_q  <= txbuf_d;
      txfull_q <= txfull_d;
      rxd_q    <= rxd_d;
      oe_q     <= oe_d;
      rdet_q   <= rdet_d;
      rxv_q    <= rxv_d;
      rdy_q    <= rdy_d;
`ifdef ONEWIRE_SLAVE_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign onewire_e = oe_q;
  assign rst_det   = rdet_q;
  assign rx_data   = rxd_q;
  assign rx_valid  = rxv_q;
  assign tx_ready  = rdy_q;

endmodule

// File: tb/tb_onewire_slave.sv
// tb_onewire_slave: directed bench for onewire_slave.
// Models the master as a pull-low on a wired-AND line.
module tb_onewire_slave;

  localparam int CW     = 8;
  localparam int T_RST  = 40;
  localparam int T_SMP  = 6;
  localparam int T_TXH  = 10;
  localparam int T_PDLY = 5;
  localparam int T_PRS  = 20;
  localparam int SLOT_LEN = 30;
  // 2 sync flops + edge detect + state entry, counted from release cycle
  localparam int PRS_START = T_PDLY + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_low;
  logic       onewire_i;
  logic       onewire_e;
  logic       rst_det;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] crc;

  assign onewire_i = ~(m_low | onewire_e);

  always #5 clk = ~clk;

  onewire_slave #(
    .CW(CW), .T_RST(T_RST), .T_SMP(T_SMP),
    .T_TXH(T_TXH), .T_PDLY(T_PDLY), .T_PRS(T_PRS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .onewire_i(onewire_i),
    .onewire_e(onewire_e),
    .rst_det(rst_det),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .crc(crc)
  );

  int nvec = 0;
  int nerr = 0;
  int n_rx = 0;
  int n_rst = 0;

  always @(negedge clk) begin
    if (rx_valid) n_rx++;
    if (rst_det) n_rst++;
  end

  typedef struct {
    logic [7:0] wr;
    logic       rd;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_oe;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_slot(input int low, output int oe_cyc);
    oe_cyc = 0;
    for (int i = 0; i < SLOT_LEN; i++) begin
      @(posedge clk);
      #1 m_low = (i < low);
      @(negedge clk);
      if (onewire_e) oe_cyc++;
    end
  endtask

  // bit 8 flags any slot whose drive length was neither 0 nor T_TXH
  task automatic do_byte(input logic [7:0] wr, input logic rd,
                         output logic [8:0] oe_res);
    int c;
    oe_res = '0;
    for (int i = 0; i < 8; i++) begin
      do_slot((rd || wr[i]) ? 2 : 12, c);
      if (c == T_TXH) oe_res[i] = 1'b1;
      else if (c != 0) oe_res[8] = 1'b1;
    end
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    chk("tx_ready_before_load", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("tx_ready_after_load", tx_ready, 0);
  endtask

  task automatic bus_reset(input int exp_oe_low);
    int n0, oe_low, first, run;
    logic clash;
    n0 = n_rst;
    oe_low = 0;
    first = 0;
    run = 0;
    clash = 1'b0;
    @(posedge clk);
    #1 m_low = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (onewire_e) oe_low++;
      if (rst_det && onewire_e) clash = 1'b1;
      @(posedge clk);
    end
    #1 m_low = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (onewire_e) begin
        if (first == 0) first = i;
        run++;
      end
    end
    chk("rst_det_pulses", n_rst - n0, 1);
    chk("oe_during_reset", {clash, oe_low[30:0]}, exp_oe_low);
    chk("presence_start", first, PRS_START);
    chk("presence_len", run, T_PRS);
    chk("tx_ready_after_presence", tx_ready, 1);
  endtask

  initial begin
    int n0, c, tot;
    logic [8:0] res;
    logic [7:0] b;
    logic rdy3;
    logic [7:0] rom[8];
    logic [7:0] crc_e1, crc_e2;

    vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{8'h00, 1'b1, 8'h3C, 8'h3C, 8'hC3};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00};
    vecs[4] = '{8'h00, 1'b1, 8'h5A, 8'h5A, 8'hA5};
    vecs[5] = '{8'h00, 1'b1, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = '{8'h00, 1'b1, 8'h00, 8'h00, 8'hFF};
    vecs[7] = '{8'h81, 1'b0, 8'h00, 8'h81, 8'h00};

    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01,
            8'h00, 8'h00, 8'h00, 8'hA2};
`ifdef ONEWIRE_SLAVE_CRC_EN
    crc_e1 = 8'hA2;
    crc_e2 = 8'h00;
`else
    crc_e1 = 8'h00;
    crc_e2 = 8'h00;
`endif

    rst = 1'b1;
    m_low = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_onewire_e", onewire_e, 0);
    chk("rst_rst_det", rst_det, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_crc", crc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    bus_reset(0);

    for (int v = 0; v < 8; v++) begin
      n0 = n_rx;
      if (vecs[v].rd) load_tx(vecs[v].tx);
      do_byte(vecs[v].wr, vecs[v].rd, res);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_rx_count", v), n_rx - n0, 1);
      chk($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      chk($sformatf("v%0d_oe_slots", v), res, {1'b0, vecs[v].exp_oe});
      chk($sformatf("v%0d_tx_ready", v), tx_ready, 1);
    end

    // rst asserted while the slave is holding a 0 bit
    load_tx(8'h00);
    @(posedge clk);
    #1 m_low = 1'b1;
    repeat (2) @(posedge clk);
    #1 m_low = 1'b0;
    repeat (4) @(negedge clk);
    chk("midslot_driving", onewire_e, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midslot_rst_release", onewire_e, 0);
    rst = 1'b0;
    tot = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (onewire_e) tot++;
    end
    chk("after_rst_no_drive", tot, 0);
    chk("after_rst_tx_ready", tx_ready, 1);

    // tx offered during slot 3 of a received byte
    b = 8'h96;
    n0 = n_rx;
    tot = 0;
    rdy3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        tx_data = 8'hE7;
        tx_valid = 1'b1;
      end
      do_slot(b[i] ? 2 : 12, c);
      tot += c;
      if (i == 3) rdy3 = tx_ready;
    end
    chk("slot3_tx_ready", rdy3, 0);
    chk("slot3_no_early_drive", tot, 0);
    chk("slot3_rx_count", n_rx - n0, 1);
    chk("slot3_rx_data", rx_data, 8'h96);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("slot3_loaded_after_byte", tx_ready, 0);
    do_byte(8'h00, 1'b1, res);
    repeat (3) @(negedge clk);
    chk("slot3_tx_oe", res, 9'h018);
    chk("slot3_tx_rx_data", rx_data, 8'hE7);
    chk("slot3_tx_ready_back", tx_ready, 1);

    // bus reset after 4 bits of a tx byte
    n0 = n_rx;
    load_tx(8'h00);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      do_slot(2, c);
      tot += c;
    end
    chk("midtx_drive_4_slots", tot, 4 * T_TXH);
    bus_reset(T_TXH);
    chk("midtx_no_rx_valid", n_rx - n0, 0);
    do_byte(8'h3C, 1'b0, res);
    repeat (3) @(negedge clk);
    chk("midtx_fresh_byte", rx_data, 8'h3C);
    chk("midtx_fresh_no_oe", res, 9'h000);

    // CRC over a ROM id, then over its own CRC byte
    bus_reset(0);
    chk("crc_cleared_by_reset", crc, 0);
    for (int i = 0; i < 7; i++) do_byte(rom[i], 1'b0, res);
    repeat (3) @(negedge clk);
    chk("crc_rom7", crc, crc_e1);
    do_byte(rom[7], 1'b0, res);
    repeat (3) @(negedge clk);
    chk("crc_rom8", crc, crc_e2);
    chk("crc_rom8_rx", rx_data, 8'hA2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
